// File: rtl/am2905_busctl.sv
// Round-robin transfer sequencer for N am2905 transceivers sharing one wired-AND bus.
// Each grant runs LOAD, DRIVE (DRIVE_CYC cycles), LATCH and DONE, all outputs registered.
module am2905_busctl #(
    parameter int N         = 4,
    parameter int DW        = 2,
    parameter int DRIVE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    srcb,
    input  logic [N*DW-1:0] dst,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    gnt,
    output logic            busy,
    output logic [N-1:0]    sel,
    output logic [N-1:0]    drcp,
    output logic [N-1:0]    be_,
    output logic [N-1:0]    rle_,
    output logic [N-1:0]    oe_
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (DRIVE_CYC > 1) ? $clog2(DRIVE_CYC) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRIVE = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state;
    logic [PW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [N-1:0]  dmask;
    logic [N-1:0]  valid;

    logic [PW-1:0] pick;
    logic [PW-1:0] scan;
    logic [PW-1:0] ptr_next;
    logic [N-1:0]  pick_hot;
    logic [N-1:0]  pick_dmask;
    logic [DW-1:0] pick_dst;

    // Scan downward from the farthest offset so the nearest requester at or after ptr wins.
    always_comb begin
        pick = ptr;
        scan = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            scan = PW'((int'(ptr) + i) % N);
            if (req[scan]) begin
                pick = scan;
            end
        end
        pick_hot = N'(1) << pick;
        pick_dst = '0;
        for (int k = 0; k < N; k++) begin
            if (pick == PW'(k)) begin
                pick_dst = dst[k*DW +: DW];
            end
        end
        // An out-of-range destination leaves the mask empty, so the word is dropped.
        pick_dmask = '0;
        for (int k = 0; k < N; k++) begin
            if (pick_dst == DW'(k)) begin
                pick_dmask[k] = 1'b1;
            end
        end
        ptr_next = (pick == PW'(N - 1)) ? '0 : pick + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state <= S_IDLE;
            ptr   <= '0;
            cnt   <= '0;
            dmask <= '0;
            valid <= '0;
            ack   <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
            sel   <= '0;
            drcp  <= '0;
            be_   <= '1;
            rle_  <= '1;
            oe_   <= '1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state     <= S_LOAD;
                        gnt       <= pick_hot;
                        drcp      <= pick_hot;
                        busy      <= 1'b1;
                        sel[pick] <= srcb[pick];
                        dmask     <= pick_dmask;
                        ptr       <= ptr_next;
                    end
                end
                S_LOAD: begin
                    drcp  <= '0;
                    be_   <= ~gnt;
                    rle_  <= ~dmask;
                    oe_   <= ~(valid & ~dmask);
                    cnt   <= '0;
                    state <= S_DRIVE;
                end
                S_DRIVE: begin
                    if (cnt == CW'(DRIVE_CYC - 1)) begin
                        rle_  <= '1;
                        state <= S_LATCH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // The latch closed one cycle earlier, so releasing the bus here keeps hold margin.
                S_LATCH: begin
                    be_   <= '1;
                    ack   <= gnt;
                    oe_   <= ~(valid | dmask);
                    valid <= valid | dmask;
                    state <= S_DONE;
                end
                S_DONE: begin
                    ack   <= '0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_am2905_busctl.sv
// Self-checking bench for am2905_busctl: phase-counting reference model plus a tiny
// behavioural model of the am2905 data path (driver register, wired-AND bus, receiver latch).
module tb_am2905_busctl;

    localparam int N  = 4;
    localparam int DW = 2;
    localparam int DC = 1;

    logic            clk = 1'b0;
    logic            rst_;
    logic [N-1:0]    req;
    logic [N-1:0]    srcb;
    logic [N*DW-1:0] dst;
    logic [N-1:0]    ack, gnt, sel, drcp, be_, rle_, oe_;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0 is idle, otherwise cycles elapsed since the grant edge.
    int           m_phase = 0;
    int           m_g     = 0;
    int           m_d     = 0;
    int           m_ptr   = 0;
    logic [N-1:0] m_valid = '0;
    logic [N-1:0] m_sel   = '0;
    logic [3:0]   m_word  = '0;

    logic [3:0] a_in [N];
    logic [3:0] b_in [N];
    logic [3:0] drv  [N];
    logic [3:0] r_out[N];
    logic [3:0] bus;

    always #5 clk = ~clk;

    am2905_busctl #(.N(N), .DW(DW), .DRIVE_CYC(DC)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .req  (req),
        .srcb (srcb),
        .dst  (dst),
        .ack  (ack),
        .gnt  (gnt),
        .busy (busy),
        .sel  (sel),
        .drcp (drcp),
        .be_  (be_),
        .rle_ (rle_),
        .oe_  (oe_)
    );

    always_comb begin
        bus = 4'hF;
        for (int k = 0; k < N; k++) begin
            if (be_[k] === 1'b0) bus = bus & drv[k];
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (drcp[k] === 1'b1) drv[k] <= sel[k] ? b_in[k] : a_in[k];
            if (rle_[k] === 1'b0) r_out[k] <= bus;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7*N:0] outs();
        return {ack, gnt, busy, sel, drcp, be_, rle_, oe_};
    endfunction

    function automatic logic [7*N:0] model_out();
        logic [N-1:0] gh, e_drcp, e_be, e_rle, e_ack, e_oe;
        gh     = (m_phase > 0) ? (N'(1) << m_g) : '0;
        e_drcp = (m_phase == 1) ? gh : '0;
        e_be   = (m_phase >= 2 && m_phase <= 2 + DC) ? ~gh : '1;
        e_ack  = (m_phase == 3 + DC) ? gh : '0;
        e_rle  = '1;
        if (m_phase >= 2 && m_phase <= 1 + DC && m_d < N) e_rle[m_d] = 1'b0;
        e_oe = ~m_valid;
        if (m_phase >= 2 && m_phase <= 2 + DC && m_d < N) e_oe[m_d] = 1'b1;
        return {e_ack, gh, (m_phase > 0), m_sel, e_drcp, e_be, e_rle, e_oe};
    endfunction

    task automatic model_step();
        bit found;
        if (rst_ !== 1'b1) begin
            m_phase = 0;
            m_ptr   = 0;
            m_valid = '0;
            m_sel   = '0;
        end else if (m_phase == 0) begin
            if (req != 0) begin
                found = 0;
                for (int i = 0; i < N; i++) begin
                    if (!found && req[(m_ptr + i) % N]) begin
                        m_g   = (m_ptr + i) % N;
                        found = 1;
                    end
                end
                m_d          = int'(dst[m_g*DW +: DW]);
                m_sel[m_g]   = srcb[m_g];
                m_word       = srcb[m_g] ? b_in[m_g] : a_in[m_g];
                m_ptr        = (m_g + 1) % N;
                m_phase      = 1;
            end
        end else if (m_phase == 3 + DC) begin
            m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == 3 + DC && m_d < N) m_valid[m_d] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        req  = '0;
        tick();
        tick();
        rst_ = 1'b1;
    endtask

    task automatic test_reset();
        logic [7*N:0] rv;
        rst_ = 1'b0;
        req  = '1;
        srcb = '1;
        dst  = '0;
        tick();
        tick();
        rv = {4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF};
        n_checks++;
        if (outs() !== rv) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got %h expected %h", outs(), rv);
        end
        n_checks++;
        if (outs() !== model_out()) begin
            n_fail++;
            $display("[TB] FAIL reset_model: got %h expected %h", outs(), model_out());
        end
        rst_ = 1'b1;
        req  = '0;
    endtask

    task automatic test_single();
        do_reset();
        b_in[0] = 4'b1010;
        a_in[0] = 4'b0101;
        req  = 4'b0001;
        srcb = 4'b0001;
        dst  = 8'b00_00_00_10;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_checks++;
            if (outs() !== model_out()) begin
                n_fail++;
                $display("[TB] FAIL single_outputs cycle %0d: got %h expected %h", c, outs(), model_out());
            end
            n_checks++;
            case (c)
                1: if ({drcp, sel[0]} !== 5'b0001_1) begin
                       n_fail++;
                       $display("[TB] FAIL single_load: drcp,sel0 got %b expected 00011", {drcp, sel[0]});
                   end
                2: if ({be_, rle_} !== 8'b1110_1011) begin
                       n_fail++;
                       $display("[TB] FAIL single_drive: be_,rle_ got %b expected 11101011", {be_, rle_});
                   end
                3: if ({be_, rle_} !== 8'b1110_1111) begin
                       n_fail++;
                       $display("[TB] FAIL single_latch: be_,rle_ got %b expected 11101111", {be_, rle_});
                   end
                4: if ({ack, oe_[2]} !== 5'b0001_0) begin
                       n_fail++;
                       $display("[TB] FAIL single_done: ack,oe2 got %b expected 00010", {ack, oe_[2]});
                   end
                default: if ({ack, busy, oe_[2]} !== 6'b0000_0_0) begin
                       n_fail++;
                       $display("[TB] FAIL single_idle: ack,busy,oe2 got %b expected 000000", {ack, busy, oe_[2]});
                   end
            endcase
            if (ack[0] === 1'b1) req = '0;
        end
        n_checks++;
        if (r_out[2] !== 4'b1010) begin
            n_fail++;
            $display("[TB] FAIL single_data: r2 got %b expected 1010", r_out[2]);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int at[$];
        do_reset();
        req  = '1;
        srcb = N'($urandom);
        dst  = (N*DW)'($urandom);
        for (int c = 1; c <= 40 && order.size() < 4; c++) begin
            tick();
            n_checks++;
            if (outs() !== model_out()) begin
                n_fail++;
                $display("[TB] FAIL rr_outputs cycle %0d: got %h expected %h", c, outs(), model_out());
            end
            if (ack != 0) begin
                for (int k = 0; k < N; k++) if (ack[k]) order.push_back(k);
                at.push_back(c);
                req = req & ~ack;
            end
            srcb = N'($urandom);
            dst  = (N*DW)'($urandom);
        end
        n_checks++;
        if (order.size() != 4 || at.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL rr_count: got %0d acks expected 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (order[i] != i) begin
                    n_fail++;
                    $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], i);
                end
            end
            n_checks++;
            if (at[0] != 3 + DC) begin
                n_fail++;
                $display("[TB] FAIL rr_first_ack: got cycle %0d expected %0d", at[0], 3 + DC);
            end
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (at[i] - at[i-1] != 4 + DC) begin
                    n_fail++;
                    $display("[TB] FAIL rr_spacing[%0d]: got %0d expected %0d", i, at[i] - at[i-1], 4 + DC);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int order[$];
        int expect_g[4] = '{0, 2, 0, 2};
        do_reset();
        req = 4'b0101;
        for (int c = 1; c <= 40 && order.size() < 4; c++) begin
            tick();
            n_checks++;
            if (outs() !== model_out()) begin
                n_fail++;
                $display("[TB] FAIL fair_outputs cycle %0d: got %h expected %h", c, outs(), model_out());
            end
            if (ack != 0) begin
                for (int k = 0; k < N; k++) if (ack[k]) order.push_back(k);
            end
        end
        req = '0;
        n_checks++;
        if (order.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL fair_count: got %0d acks expected 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (order[i] != expect_g[i]) begin
                    n_fail++;
                    $display("[TB] FAIL fair_order[%0d]: got %0d expected %0d", i, order[i], expect_g[i]);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_drive();
        bit acked;
        do_reset();
        req  = 4'b0100;
        dst  = 8'b11_11_11_11;
        tick();
        tick();
        rst_ = 1'b0;
        req  = '0;
        tick();
        n_checks++;
        if ({ack, be_, rle_, oe_, busy} !== {4'h0, 4'hF, 4'hF, 4'hF, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL midrst_values: ack,be_,rle_,oe_,busy got %b", {ack, be_, rle_, oe_, busy});
        end
        rst_ = 1'b1;
        req  = 4'b1100;
        tick();
        n_checks++;
        if ({gnt, drcp} !== 8'b0100_0100) begin
            n_fail++;
            $display("[TB] FAIL midrst_regrant: gnt,drcp got %b expected 01000100", {gnt, drcp});
        end
        req   = '0;
        acked = 0;
        for (int c = 2; c <= 10; c++) begin
            tick();
            n_checks++;
            if (outs() !== model_out()) begin
                n_fail++;
                $display("[TB] FAIL midrst_outputs cycle %0d: got %h expected %h", c, outs(), model_out());
            end
            if (ack === 4'b0100) acked = 1;
        end
        n_checks++;
        if (!acked) begin
            n_fail++;
            $display("[TB] FAIL midrst_ack: ack[2] got none expected one pulse");
        end
    endtask

    task automatic test_retarget();
        logic [0:4] oe1_exp = 5'b0_1_1_0_0;
        do_reset();
        b_in[0] = 4'b1100;
        a_in[3] = 4'b0110;
        b_in[3] = 4'b1001;
        req  = 4'b0001;
        srcb = 4'b0001;
        dst  = 8'b01_00_00_01;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (ack[0] === 1'b1) req = '0;
        end
        n_checks++;
        if ({r_out[1], oe_[1]} !== 5'b1100_0) begin
            n_fail++;
            $display("[TB] FAIL retarget_first: r1,oe1 got %b expected 11000", {r_out[1], oe_[1]});
        end
        req  = 4'b1000;
        srcb = 4'b0000;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_checks++;
            if (oe_[1] !== oe1_exp[c-1]) begin
                n_fail++;
                $display("[TB] FAIL retarget_oe1 cycle %0d: got %b expected %b", c, oe_[1], oe1_exp[c-1]);
            end
            n_checks++;
            if (outs() !== model_out()) begin
                n_fail++;
                $display("[TB] FAIL retarget_outputs cycle %0d: got %h expected %h", c, outs(), model_out());
            end
            if (ack[3] === 1'b1) req = '0;
        end
        n_checks++;
        if (r_out[1] !== 4'b0110) begin
            n_fail++;
            $display("[TB] FAIL retarget_data: r1 got %b expected 0110", r_out[1]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < N; k++) begin
            a_in[k] = 4'($urandom);
            b_in[k] = 4'($urandom);
        end
        for (int c = 0; c < 400; c++) begin
            rst_ = ($urandom_range(0, 39) != 0);
            req  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            srcb = N'($urandom);
            dst  = (N*DW)'($urandom);
            tick();
            n_checks++;
            if (outs() !== model_out()) begin
                n_fail++;
                $display("[TB] FAIL random_outputs cycle %0d: got %h expected %h", c, outs(), model_out());
            end
            n_checks++;
            if ($countones(~be_) > 1) begin
                n_fail++;
                $display("[TB] FAIL random_be_onehot cycle %0d: be_ got %b expected at most one low", c, be_);
            end
            if (m_phase == 3 + DC && m_d < N) begin
                n_checks++;
                if (r_out[m_d] !== m_word) begin
                    n_fail++;
                    $display("[TB] FAIL random_data cycle %0d: r%0d got %b expected %b", c, m_d, r_out[m_d], m_word);
                end
            end
        end
        rst_ = 1'b1;
        req  = '0;
    endtask

    initial begin
        rst_ = 1'b0;
        req  = '0;
        srcb = '0;
        dst  = '0;
        for (int k = 0; k < N; k++) begin
            a_in[k] = '0;
            b_in[k] = '0;
        end
        $display("[TB] starting am2905_busctl bench");
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_reset_mid_drive();
        test_retarget();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
